// File: rtl/ub_access_ctrl.sv
// Unified-buffer access controller: sequences burst reads on BRAM port B and
// round-robin arbitrates host load vs accumulator writeback onto BRAM port A.
module ub_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  // burst read request / delivery
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  // host load requester
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  // accumulator writeback requester
  input  logic              acc_wr_valid,
  input  logic [ADDR_W-1:0] acc_wr_addr,
  input  logic [DATA_W-1:0] acc_wr_data,
  output logic              acc_wr_ready,
  // BRAM pins
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic              zero_len;

  logic              last_acc;
  logic              grant_host;
  logic              grant_acc;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  // ---------------------------------------------------------------------------
  // Read sequencer. bram_addrb doubles as the running burst address.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      zero_len   <= 1'b0;
      rd_busy    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_done    <= 1'b0;
      bram_enb   <= 1'b0;
      bram_addrb <= '0;
    end else begin
      rd_valid <= bram_enb;
      case (state)
        IDLE: begin
          if (rd_start) begin
            rd_busy <= 1'b1;
            if (rd_len != '0) begin
              state      <= READ;
              cnt        <= rd_len;
              bram_enb   <= 1'b1;
              bram_addrb <= rd_base;
            end else begin
              state    <= DRAIN;
              zero_len <= 1'b1;
            end
          end
        end
        READ: begin
          if (cnt == LEN_W'(1)) begin
            // last row issued; its data lands together with rd_done
            state    <= DRAIN;
            bram_enb <= 1'b0;
            rd_done  <= 1'b1;
          end else begin
            bram_addrb <= bram_addrb + ADDR_W'(1);
            cnt        <= cnt - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (zero_len) begin
            // empty burst: one spacer cycle so rd_done lands two cycles after start
            zero_len <= 1'b0;
            rd_done  <= 1'b1;
          end else begin
            state   <= IDLE;
            rd_done <= 1'b0;
            rd_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data = bram_doutb;

  // ---------------------------------------------------------------------------
  // Write arbiter: combinational grant, pointer remembers the last winner.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_host = 1'b0;
    grant_acc  = 1'b0;
    if (!reset) begin
      if (host_wr_valid && (!acc_wr_valid || last_acc)) grant_host = 1'b1;
      else if (acc_wr_valid)                            grant_acc  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_acc  <= 1'b1;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (grant_host) begin
      last_acc  <= 1'b0;
      hold_addr <= host_wr_addr;
      hold_data <= host_wr_data;
    end else if (grant_acc) begin
      last_acc  <= 1'b1;
      hold_addr <= acc_wr_addr;
      hold_data <= acc_wr_data;
    end
  end

  assign host_wr_ready = grant_host;
  assign acc_wr_ready  = grant_acc;
  assign bram_wea      = grant_host | grant_acc;

  // Port A pins keep the last written address/data while idle.
  assign bram_addra = grant_host ? host_wr_addr :
                      grant_acc  ? acc_wr_addr  : hold_addr;
  assign bram_dina  = grant_host ? host_wr_data :
                      grant_acc  ? acc_wr_data  : hold_data;

endmodule

// File: tb/tb_ub_access_ctrl.sv
// Directed bench for ub_access_ctrl with a read-before-write BRAM model and
// table-driven arbiter vectors.
module tb_ub_access_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_start;
  logic [7:0]   rd_base;
  logic [8:0]   rd_len;
  logic         rd_busy, rd_valid, rd_done;
  logic [127:0] rd_data;
  logic         host_wr_valid, host_wr_ready;
  logic [7:0]   host_wr_addr;
  logic [127:0] host_wr_data;
  logic         acc_wr_valid, acc_wr_ready;
  logic [7:0]   acc_wr_addr;
  logic [127:0] acc_wr_data;
  logic         bram_wea, bram_enb;
  logic [7:0]   bram_addra, bram_addrb;
  logic [127:0] bram_dina, bram_doutb;

  int errors = 0;
  int checks = 0;

  logic [127:0] mem     [256];
  logic [127:0] exp_mem [256];

  ub_access_ctrl dut (
    .clk(clk), .reset(reset),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .acc_wr_valid(acc_wr_valid), .acc_wr_addr(acc_wr_addr),
    .acc_wr_data(acc_wr_data), .acc_wr_ready(acc_wr_ready),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  always #5 clk = ~clk;

  // Registered-output BRAM, read-before-write on a same-row collision.
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  typedef struct {
    logic       hv;
    logic       av;
    logic [7:0] ha;
    logic [7:0] aa;
    logic       ehr;
    logic       ear;
    logic [7:0] eaddr;
  } arb_vec_t;

  arb_vec_t vecs [11];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst from the current cycle T and checks every cycle up to one
  // past rd_done. inject_at > 0 raises a stray rd_start in that burst cycle.
  task automatic run_burst(input logic [7:0] base, input int len, input int inject_at);
    int         done_k;
    logic       e_enb, e_valid, e_done, e_busy;
    logic [7:0] e_addr;
    logic [7:0] row;
    done_k   = (len == 0) ? 2 : len + 1;
    rd_start = 1'b1;
    rd_base  = base;
    rd_len   = 9'(len);
    tick();
    for (int k = 1; k <= done_k + 1; k++) begin
      if (k == inject_at) begin
        rd_start = 1'b1;
        rd_base  = 8'h40;
        rd_len   = 9'd2;
      end else begin
        rd_start = 1'b0;
      end
      #1;
      e_enb   = (k <= len);
      e_addr  = e_enb ? 8'(int'(base) + k - 1) : 8'h00;
      e_valid = (k >= 2) && (k <= len + 1);
      e_done  = (k == done_k);
      e_busy  = (k <= done_k);
      check("burst_ctrl",
            {bram_enb, (bram_enb ? bram_addrb : 8'h00), rd_valid, rd_done, rd_busy},
            {e_enb, e_addr, e_valid, e_done, e_busy});
      if (e_valid) begin
        row = 8'(int'(base) + k - 2);
        check("burst_data", rd_data, exp_mem[row]);
      end
      tick();
    end
    rd_start = 1'b0;
  endtask

  initial begin
    int           miss;
    logic [127:0] exp_dina;
    logic [127:0] hd, ad;

    reset = 1'b1; rd_start = 1'b0; rd_base = '0; rd_len = '0;
    host_wr_valid = 1'b1; host_wr_addr = 8'h07; host_wr_data = 128'h7;
    acc_wr_valid  = 1'b1; acc_wr_addr  = 8'h08; acc_wr_data  = 128'h8;

    // Writes must be blocked while reset is high.
    tick(); tick();
    check("reset_blocks_writes", {host_wr_ready, acc_wr_ready, bram_wea}, 3'b000);
    host_wr_valid = 1'b0; acc_wr_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("reset_ctrl_outputs",
          {rd_busy, rd_valid, rd_done, bram_enb, bram_wea, host_wr_ready, acc_wr_ready}, 7'b0);
    check("reset_port_addrs", {bram_addrb, bram_addra}, 16'h0);
    check("reset_dina", bram_dina, 128'h0);

    // Arbiter vectors: fresh pointer means host wins the first tie.
    vecs[0]  = '{1'b1, 1'b1, 8'h80, 8'h90, 1'b1, 1'b0, 8'h80};
    vecs[1]  = '{1'b1, 1'b1, 8'h81, 8'h91, 1'b0, 1'b1, 8'h91};
    vecs[2]  = '{1'b1, 1'b1, 8'h82, 8'h92, 1'b1, 1'b0, 8'h82};
    vecs[3]  = '{1'b1, 1'b1, 8'h83, 8'h93, 1'b0, 1'b1, 8'h93};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h94, 1'b0, 1'b1, 8'h94};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h95, 1'b0, 1'b1, 8'h95};
    vecs[6]  = '{1'b1, 1'b1, 8'h84, 8'h96, 1'b1, 1'b0, 8'h84};
    vecs[7]  = '{1'b1, 1'b1, 8'h85, 8'h97, 1'b0, 1'b1, 8'h97};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h97};
    vecs[9]  = '{1'b1, 1'b0, 8'h86, 8'h00, 1'b1, 1'b0, 8'h86};
    vecs[10] = '{1'b1, 1'b1, 8'h87, 8'h98, 1'b0, 1'b1, 8'h98};

    exp_dina = 128'h0;
    for (int i = 0; i < 11; i++) begin
      hd = {120'h0, vecs[i].ha};
      ad = {120'h1, vecs[i].aa};
      host_wr_valid = vecs[i].hv; host_wr_addr = vecs[i].ha; host_wr_data = hd;
      acc_wr_valid  = vecs[i].av; acc_wr_addr  = vecs[i].aa; acc_wr_data  = ad;
      if (vecs[i].ehr)      exp_dina = hd;
      else if (vecs[i].ear) exp_dina = ad;
      #1;
      check($sformatf("arb_grant[%0d]", i), {host_wr_ready, acc_wr_ready, bram_wea},
            {vecs[i].ehr, vecs[i].ear, vecs[i].ehr | vecs[i].ear});
      check($sformatf("arb_addra[%0d]", i), bram_addra, vecs[i].eaddr);
      check($sformatf("arb_dina[%0d]", i), bram_dina, exp_dina);
      tick();
    end
    host_wr_valid = 1'b0; acc_wr_valid = 1'b0;

    // Fill every row with its own index replicated across the lanes.
    miss = 0;
    for (int i = 0; i < 256; i++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = 8'(i);
      host_wr_data  = {16{8'(i)}};
      exp_mem[i]    = {16{8'(i)}};
      #1;
      if (!host_wr_ready || !bram_wea || bram_addra !== 8'(i)) miss++;
      tick();
    end
    host_wr_valid = 1'b0;
    check("preload_ready_misses", 32'(miss), 32'd0);

    // Basic burst, wrap across 0xFF, full-depth burst, empty burst.
    run_burst(8'h10, 4, 0);
    run_burst(8'hFE, 4, 0);
    run_burst(8'h00, 256, 0);
    run_burst(8'h33, 0, 0);

    // Host-loaded rows read back in order.
    for (int i = 0; i < 4; i++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = 8'(i);
      host_wr_data  = 128'(8'h11 * (i + 1));
      exp_mem[i]    = 128'(8'h11 * (i + 1));
      tick();
    end
    host_wr_valid = 1'b0;
    run_burst(8'h00, 4, 0);

    // Stray rd_start mid-burst must not disturb the running burst.
    run_burst(8'h20, 6, 2);

    // Reset mid-burst: abort, no rd_done, then a clean burst.
    rd_start = 1'b1; rd_base = 8'h30; rd_len = 9'd8;
    tick();
    rd_start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    host_wr_valid = 1'b1; host_wr_addr = 8'h31; host_wr_data = 128'hDEAD;
    #1;
    check("midreset_write_blocked", {host_wr_ready, bram_wea}, 2'b00);
    tick();
    reset = 1'b0;
    host_wr_valid = 1'b0;
    #1;
    check("midreset_outputs",
          {rd_busy, rd_valid, rd_done, bram_enb, bram_wea, host_wr_ready, acc_wr_ready}, 7'b0);
    miss = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rd_done || rd_busy || rd_valid || bram_enb) miss++;
    end
    check("midreset_no_done", 32'(miss), 32'd0);
    tick();
    run_burst(8'h30, 3, 0);

    // Same-row write/read collision returns the old row.
    rd_start = 1'b1; rd_base = 8'h05; rd_len = 9'd1;
    tick();
    rd_start = 1'b0;
    acc_wr_valid = 1'b1; acc_wr_addr = 8'h05; acc_wr_data = 128'hAB;
    #1;
    check("hazard_same_cycle", {acc_wr_ready, bram_enb, bram_addrb}, {1'b1, 1'b1, 8'h05});
    tick();
    acc_wr_valid = 1'b0;
    #1;
    check("hazard_old_data", {rd_valid, rd_done, rd_data}, {1'b1, 1'b1, {16{8'h05}}});
    exp_mem[5] = 128'hAB;
    tick(); tick();
    run_burst(8'h05, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
